// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I pipeline types for forwarding selects and decode constants
package riscv_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;
endpackage

// File: rtl/hazard_unit.sv
// hazard_unit: registered EX forwarding selects, load-use stall, branch flush and
// saturating stall/flush counters, driven from a shadow copy of the E/M/W register tags
module hazard_unit
  import riscv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  reg_write_d,
  input  logic [1:0]            result_src_d,
  input  logic                  pc_src_e,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  logic [REG_ADDR_W-1:0] r_rs1_e, r_rs2_e, r_rd_e, r_rd_m, r_rd_w;
  logic                  r_rw_e, r_ld_e, r_rw_m, r_rw_w;
  fwd_sel_t              r_fwd_a, r_fwd_b;
  logic [CNT_W-1:0]      r_stall_cnt, r_flush_cnt;
  logic                  w_lw_stall, w_flush_e;
  fwd_sel_t              w_pred_a, w_pred_b;

  // The nearer (EX) writer shadows an older MEM writer of the same register.
  function automatic fwd_sel_t predict(input logic [REG_ADDR_W-1:0] rs);
    return (r_rw_e && r_rd_e != '0 && rs == r_rd_e) ? FWD_MEM :
           (r_rw_m && r_rd_m != '0 && rs == r_rd_m) ? FWD_WB : FWD_REG;
  endfunction

  always_comb begin
    w_lw_stall = r_ld_e && r_rd_e != '0 && (rs1_d == r_rd_e || rs2_d == r_rd_e);
    w_flush_e  = w_lw_stall || pc_src_e;
    w_pred_a   = predict(rs1_d);
    w_pred_b   = predict(rs2_d);
  end

  always_ff @(posedge clk) begin
    if (reset || w_flush_e) begin
      r_rs1_e <= '0;
      r_rs2_e <= '0;
      r_rd_e  <= '0;
      r_rw_e  <= 1'b0;
      r_ld_e  <= 1'b0;
      r_fwd_a <= FWD_REG;
      r_fwd_b <= FWD_REG;
    end else begin
      r_rs1_e <= rs1_d;
      r_rs2_e <= rs2_d;
      r_rd_e  <= rd_d;
      r_rw_e  <= reg_write_d;
      r_ld_e  <= reg_write_d && result_src_d == RESULT_SRC_LOAD;
      r_fwd_a <= w_pred_a;
      r_fwd_b <= w_pred_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_m      <= '0;
      r_rw_m      <= 1'b0;
      r_rd_w      <= '0;
      r_rw_w      <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_rd_m      <= r_rd_e;
      r_rw_m      <= r_rw_e;
      r_rd_w      <= r_rd_m;
      r_rw_w      <= r_rw_m;
      r_stall_cnt <= r_stall_cnt + CNT_W'(w_lw_stall && r_stall_cnt != '1);
      r_flush_cnt <= r_flush_cnt + CNT_W'(pc_src_e && r_flush_cnt != '1);
    end
  end

  assign forward_a_e = r_fwd_a;
  assign forward_b_e = r_fwd_b;
  assign stall_f     = w_lw_stall;
  assign stall_d     = w_lw_stall;
  assign flush_d     = pc_src_e;
  assign flush_e     = w_flush_e;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

  // A registered select must name the stage that now really holds the producer.
  a_fwd_a_mem: assert property (@(posedge clk) disable iff (reset)
    r_fwd_a == FWD_MEM |-> r_rw_m && r_rd_m != '0 && r_rs1_e == r_rd_m);
  a_fwd_b_mem: assert property (@(posedge clk) disable iff (reset)
    r_fwd_b == FWD_MEM |-> r_rw_m && r_rd_m != '0 && r_rs2_e == r_rd_m);
  a_fwd_a_wb: assert property (@(posedge clk) disable iff (reset)
    r_fwd_a == FWD_WB |-> r_rw_w && r_rd_w != '0 && r_rs1_e == r_rd_w);
  a_fwd_b_wb: assert property (@(posedge clk) disable iff (reset)
    r_fwd_b == FWD_WB |-> r_rw_w && r_rd_w != '0 && r_rs2_e == r_rd_w);
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scenarios for forwarding, load-use stall, flush and counters
module tb_hazard_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rs1_d = '0, rs2_d = '0, rd_d = '0;
  logic        reg_write_d = 1'b0;
  logic [1:0]  result_src_d = '0;
  logic        pc_src_e = 1'b0;
  logic [1:0]  forward_a_e, forward_b_e, fa_s, fb_s;
  logic        stall_f, stall_d, flush_d, flush_e, sf_s, sd_s, fd_s, fe_s;
  logic [15:0] stall_cnt, flush_cnt;
  logic [2:0]  stall_cnt_s, flush_cnt_s;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .result_src_d(result_src_d), .pc_src_e(pc_src_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .stall_f(stall_f),
    .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_unit #(.CNT_W(3)) sat (
    .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .result_src_d(result_src_d), .pc_src_e(pc_src_e),
    .forward_a_e(fa_s), .forward_b_e(fb_s), .stall_f(sf_s),
    .stall_d(sd_s), .flush_d(fd_s), .flush_e(fe_s),
    .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic [1:0] rs, input logic pc);
    rs1_d = rs1; rs2_d = rs2; rd_d = rd; reg_write_d = rw; result_src_d = rs; pc_src_e = pc;
  endtask

  task automatic bubbles(input int n);
    set_d(0, 0, 0, 0, 2'b00, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    set_d(0, 0, 0, 0, 2'b00, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if ({forward_a_e, forward_b_e} !== 4'b0) begin errors++; $display("FAIL reset_fwd got %b want 0000", {forward_a_e, forward_b_e}); end
    checks++; if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got %b want 0000", {stall_f, stall_d, flush_d, flush_e}); end
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %h/%h want 0/0", stall_cnt, flush_cnt); end
    checks++; if (stall_cnt_s !== 3'd0 || flush_cnt_s !== 3'd0) begin errors++; $display("FAIL reset_cnt_sat got %h/%h want 0/0", stall_cnt_s, flush_cnt_s); end
    bubbles(3);
    checks++; if ({forward_a_e, forward_b_e} !== 4'b0) begin errors++; $display("FAIL idle_fwd got %b want 0000", {forward_a_e, forward_b_e}); end
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL idle_cnt got %h/%h want 0/0", stall_cnt, flush_cnt); end
  endtask

  task automatic test_ex_ex();
    set_d(1, 2, 5, 1, 2'b00, 0);
    tick();
    set_d(5, 6, 8, 1, 2'b00, 0);
    #1;
    checks++; if (stall_f !== 1'b0) begin errors++; $display("FAIL exex_nostall got %b want 0", stall_f); end
    tick();
    checks++; if (forward_a_e !== 2'b10) begin errors++; $display("FAIL exex_fwd_a got %b want 10", forward_a_e); end
    checks++; if (forward_b_e !== 2'b00) begin errors++; $display("FAIL exex_fwd_b got %b want 00", forward_b_e); end
    bubbles(3);
  endtask

  task automatic test_mem_ex();
    set_d(1, 2, 7, 1, 2'b00, 0);
    tick();
    set_d(1, 2, 10, 1, 2'b00, 0);
    tick();
    set_d(0, 7, 11, 1, 2'b00, 0);
    tick();
    checks++; if (forward_b_e !== 2'b01) begin errors++; $display("FAIL memex_fwd_b got %b want 01", forward_b_e); end
    checks++; if (forward_a_e !== 2'b00) begin errors++; $display("FAIL memex_fwd_a got %b want 00", forward_a_e); end
    bubbles(3);
  endtask

  task automatic test_double_hit();
    set_d(1, 2, 3, 1, 2'b00, 0);
    tick();
    set_d(1, 2, 3, 1, 2'b00, 0);
    tick();
    set_d(3, 4, 12, 1, 2'b00, 0);
    tick();
    checks++; if (forward_a_e !== 2'b10) begin errors++; $display("FAIL double_fwd_a got %b want 10", forward_a_e); end
    bubbles(3);
  endtask

  task automatic test_load_use();
    set_d(1, 2, 9, 1, 2'b01, 0);
    tick();
    set_d(9, 0, 11, 1, 2'b00, 0);
    #1;
    checks++; if ({stall_f, stall_d, flush_d, flush_e} !== 4'b1101) begin errors++; $display("FAIL lu_ctrl got %b want 1101", {stall_f, stall_d, flush_d, flush_e}); end
    tick();
    checks++; if ({stall_f, stall_d, flush_e} !== 3'b000) begin errors++; $display("FAIL lu_release got %b want 000", {stall_f, stall_d, flush_e}); end
    checks++; if (forward_a_e !== 2'b00) begin errors++; $display("FAIL lu_bubble_fwd got %b want 00", forward_a_e); end
    tick();
    checks++; if (forward_a_e !== 2'b01) begin errors++; $display("FAIL lu_fwd_a got %b want 01", forward_a_e); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt); end
    bubbles(3);
    set_d(0, 0, 0, 1, 2'b01, 0);
    tick();
    set_d(0, 0, 12, 1, 2'b00, 0);
    #1;
    checks++; if (stall_f !== 1'b0) begin errors++; $display("FAIL x0_nostall got %b want 0", stall_f); end
    tick();
    checks++; if ({forward_a_e, forward_b_e} !== 4'b0) begin errors++; $display("FAIL x0_fwd got %b want 0000", {forward_a_e, forward_b_e}); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL x0_stall_cnt got %0d want 1", stall_cnt); end
    bubbles(3);
  endtask

  task automatic test_branch_load_use();
    set_d(1, 2, 4, 1, 2'b01, 0);
    tick();
    set_d(4, 4, 13, 1, 2'b00, 1);
    #1;
    checks++; if ({stall_f, stall_d, flush_d, flush_e} !== 4'b1111) begin errors++; $display("FAIL br_ctrl got %b want 1111", {stall_f, stall_d, flush_d, flush_e}); end
    tick();
    checks++; if ({forward_a_e, forward_b_e} !== 4'b0) begin errors++; $display("FAIL br_fwd got %b want 0000", {forward_a_e, forward_b_e}); end
    checks++; if (stall_cnt !== 16'd2 || flush_cnt !== 16'd1) begin errors++; $display("FAIL br_cnt got %0d/%0d want 2/1", stall_cnt, flush_cnt); end
    bubbles(3);
  endtask

  task automatic test_saturation();
    set_d(0, 0, 0, 0, 2'b00, 1);
    for (int i = 0; i < 6; i++) tick();
    checks++; if (flush_cnt_s !== 3'd7) begin errors++; $display("FAIL sat_reach got %0d want 7", flush_cnt_s); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (flush_cnt_s !== 3'd7) begin errors++; $display("FAIL sat_hold got %0d want 7", flush_cnt_s); end
    checks++; if (flush_cnt !== 16'd11) begin errors++; $display("FAIL wide_flush_cnt got %0d want 11", flush_cnt); end
    checks++; if (stall_cnt_s !== 3'd2) begin errors++; $display("FAIL sat_stall_cnt got %0d want 2", stall_cnt_s); end
    bubbles(3);
  endtask

  task automatic test_reset_mid_stall();
    set_d(1, 2, 9, 1, 2'b01, 0);
    tick();
    set_d(9, 0, 11, 1, 2'b00, 0);
    #1;
    checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL rms_pre got %b want 1", stall_f); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if ({stall_f, stall_d, flush_e} !== 3'b000) begin errors++; $display("FAIL rms_ctrl got %b want 000", {stall_f, stall_d, flush_e}); end
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL rms_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    tick();
    checks++; if ({forward_a_e, forward_b_e} !== 4'b0) begin errors++; $display("FAIL rms_fwd got %b want 0000", {forward_a_e, forward_b_e}); end
  endtask

  initial begin
    test_reset();
    test_ex_ex();
    test_mem_ex();
    test_double_hit();
    test_load_use();
    test_branch_load_use();
    test_saturation();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage RV32I core. It drives the 2-bit select inputs of the EX-stage 3:1 operand forwarding muxes, which pick between the register-file operand, the WB result and the MEM ALU result. It also generates the load-use stall and the branch flush controls. The unit keeps its own shadow copy of the register tags of the EX, MEM and WB stages, so that the forwarding selects leave it registered and aligned with the instruction in EX.

## Interface
Parameters:
- CNT_W, 16, width of the saturating performance counters

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- rs1_d  in  5  decode-stage source register 1
- rs2_d  in  5  decode-stage source register 2
- rd_d  in  5  decode-stage destination
- reg_write_d  in  1  decode-stage instruction writes rd
- result_src_d  in  2  decode-stage result source (2'b01 = load)
- pc_src_e  in  1  branch/jump taken, resolved in EX
- forward_a_e  out  2  select for the SrcA forwarding mux, registered
- forward_b_e  out  2  select for the SrcB forwarding mux, registered
- stall_f  out  1  hold PC
- stall_d  out  1  hold IF/ID register
- flush_d  out  1  clear IF/ID register
- flush_e  out  1  clear ID/EX register
- stall_cnt  out  CNT_W  count of load-use stall cycles, saturating
- flush_cnt  out  CNT_W  count of taken-branch flush cycles, saturating

## Operation
Select encoding:
- 00: register-file operand.
- 01: WB result.
- 10: MEM ALU result.
- 11: never driven.

Shadow pipeline:
- E stage holds rs1, rs2, rd, reg_write and is_load.
- M stage and W stage each hold rd and reg_write.
- M and W advance every cycle.
- E loads from the decode inputs, or is cleared to a bubble (all zero) when flush_e = 1.

Load-use stall, combinational:
- lw_stall = is_load_e & rd_e != 0 & (rs1_d == rd_e | rs2_d == rd_e).

Control outputs, combinational:
- stall_f = stall_d = lw_stall.
- flush_d = pc_src_e.
- flush_e = lw_stall | pc_src_e.

Forward-select prediction, computed in decode for use next cycle. For rs1 (rs2 is identical):
- 10 if reg_write_e & rd_e != 0 & rs1_d == rd_e.
- Otherwise 01 if reg_write_m & rd_m != 0 & rs1_d == rd_m.
- Otherwise 00.
- The nearer stage always wins.

Forward-select register:
- If flush_e = 1, loads 00.
- Otherwise loads the prediction.

WB-to-decode hazards are not handled here. The register file is write-through.

Counters:
- stall_cnt increments on every lw_stall cycle.
- flush_cnt increments on every pc_src_e cycle.
- Both saturate at all-ones and never wrap.

## Timing
- Reset: all shadow registers, forward_a_e/forward_b_e and both counters clear to 0 at the clk edge where reset = 1.
- Combinational outputs settle from the cleared state, so all outputs are 0 after reset.
- Forward selects: 1-cycle latency. The decode-cycle comparison appears on forward_*_e in the cycle that instruction is in EX.
- lw_stall and pc_src_e in the same cycle:
  - flush_e = 1, and the E bubble and 00 selects are loaded.
  - stall_f, stall_d and flush_d are all 1; the core gives flush precedence.
  - Both counters increment.
- Stall sequence:
  - The dependent instruction spends 2 cycles in decode.
  - In its second decode cycle the load sits in M.
  - It then enters EX with select 01.
- rd = x0 never forwards and never stalls.
- reset mid-stall: the stall and shadow state drop in the next cycle. There is no residual bubble.

## Structure
- Shared riscv_pkg holds:
  - fwd_sel_t enum: FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - RESULT_SRC_LOAD = 2'b01.
  - REG_ADDR_W = 5.
- The datapath forwarding mux uses the same enum.
- Single module, no sub-modules. The two forward-select comparisons can share one function.

## Test plan
- After reset: all outputs 0. Bubble decode inputs for 3 cycles: selects stay 00, counters stay 0.
- EX→EX dependency: add x5 at decode, then the next decode reads rs1 = x5. When the second instruction is in EX: forward_a_e = 10, forward_b_e = 00.
- MEM→EX dependency: writer of x7, then an independent instruction, then a decode reading rs2 = x7. In EX: forward_b_e = 01.
- Double hit: two consecutive writers of x3, then a decode reading rs1 = x3. Select = 10, the nearer stage.
- Load-use:
  - lw x9, then a decode reading rs1 = x9.
  - Response: one cycle of stall_f = stall_d = flush_e = 1, then select 01 in EX, stall_cnt = 1.
  - rd = x0 writers never forward: select stays 00.
- Branch with simultaneous load-use:
  - pc_src_e = 1 while lw_stall = 1.
  - Response: flush_d = flush_e = 1, next-cycle selects 00, both counters increment.
  - Saturation check: preload 16'hFFFF, counter holds at 16'hFFFF.
